// File: rtl/fetch_issue_unit_pkg.sv
// rtl/fetch_issue_unit_pkg.sv - shared fetch constants, bubble word and fetch FSM encoding
package fetch_issue_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    // Also the wall's clear value and the hazard unit's injected NOP.
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_issue_unit_fifo.sv
// rtl/fetch_issue_unit_fifo.sv - instruction/pc FIFO with flush and combinational head
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!flush) && ((count != FULL_CNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - PC owner and imem fetcher feeding the IF/ID wall
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] BUBBLE   = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        fetch_valid
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);

    fetch_state_t      state;
    logic [XLEN-1:0]   fetch_pc;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;
    logic              credit_ok;

    assign fetch_valid = (count != '0);
    assign push        = (state == S_WAIT) && imem_ack && !redirect;
    assign pop         = fetch_valid && !stall && !redirect;

    // Occupancy after this edge; a new request is only issued if its
    // response is guaranteed a free slot.
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end
    assign credit_ok = (count_next < DEPTH_C);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_rdata, fetch_pc}),
        .head  (head),
        .count (count)
    );

    assign inst_out     = fetch_valid ? head[2*XLEN-1:XLEN] : BUBBLE;
    assign pc_out       = fetch_valid ? head[XLEN-1:0] : '0;
    assign pc_plus4_out = fetch_valid ? (head[XLEN-1:0] + STEP) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
            end else if (push) begin
                fetch_pc <= fetch_pc + STEP;
            end

            case (state)
                S_IDLE: begin
                    if (!redirect && credit_ok) begin
                        state     <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        if (credit_ok) begin
                            imem_addr <= fetch_pc + STEP;
                        end else begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    // The stale request cannot be withdrawn; swallow its response.
                    if (imem_ack) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb/tb_fetch_issue_unit.sv - directed self-checking bench for fetch_issue_unit
module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        fetch_valid;

    int vectors = 0;
    int miscompares = 0;

    int   lat = 0;
    logic ack_block = 1'b0;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    fetch_issue_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out),
        .fetch_valid  (fetch_valid)
    );

    // Memory returns addr ^ 0xDEAD0000 after `lat` wait cycles.
    always_comb begin
        imem_ack   = imem_req && !ack_block && (wait_cnt >= lat);
        imem_rdata = imem_ack ? (imem_addr ^ 32'hDEAD_0000) : 32'h0;
    end

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        ack_block = 1'b0; lat = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b exp 0", fetch_valid); end
        vectors++; if (inst_out !== 32'h0) begin miscompares++; $display("FAIL rst_inst got %h exp 00000000", inst_out); end
        vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 00000000", pc_out); end
        vectors++; if (pc_plus4_out !== 32'h0) begin miscompares++; $display("FAIL rst_pc4 got %h exp 00000000", pc_plus4_out); end
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first req=%0b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid got %0b exp 0", fetch_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++; if (imem_addr !== 32'(4 * (i + 1))) begin miscompares++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * (i + 1))); end
            vectors++; if (fetch_valid !== 1'b1 || pc_out !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_pc[%0d] valid=%0b pc=%h exp valid=1 pc=%h", i, fetch_valid, pc_out, 32'(4 * i)); end
            vectors++; if (inst_out !== (32'hDEAD_0000 | 32'(4 * i))) begin miscompares++; $display("FAIL stream_inst[%0d] got %h exp %h", i, inst_out, 32'hDEAD_0000 | 32'(4 * i)); end
            vectors++; if (pc_plus4_out !== 32'(4 * i + 4)) begin miscompares++; $display("FAIL stream_pc4[%0d] got %h exp %h", i, pc_plus4_out, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d] got %0b exp 0", i, imem_req); end
            vectors++; if (fetch_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'hDEAD_0000) begin miscompares++; $display("FAIL stall_hold[%0d] valid=%0b pc=%h inst=%h exp 1/00000000/dead0000", i, fetch_valid, pc_out, inst_out); end
            if (i < 2) @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        vectors++; if (pc_out !== 32'h4 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL stall_rel_pc4 got %h valid=%0b exp 00000004", pc_out, fetch_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_rel_req req=%0b addr=%h exp 1/00000008", imem_req, imem_addr); end
        @(negedge clk);
        vectors++; if (pc_out !== 32'h8 || inst_out !== 32'hDEAD_0008) begin miscompares++; $display("FAIL stall_rel_pc8 pc=%h inst=%h exp 00000008/dead0008", pc_out, inst_out); end
    endtask

    task automatic test_latency();
        do_reset();
        lat = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL lat_wait[%0d] req=%0b addr=%h valid=%0b exp 1/00000000/0", i, imem_req, imem_addr, fetch_valid); end
        end
        @(negedge clk);
        vectors++; if (fetch_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'hDEAD_0000) begin miscompares++; $display("FAIL lat_first valid=%0b pc=%h inst=%h exp 1/00000000/dead0000", fetch_valid, pc_out, inst_out); end
        vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL lat_addr4 got %h exp 00000004", imem_addr); end
        @(negedge clk);
        vectors++; if (fetch_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0) begin miscompares++; $display("FAIL lat_bubble valid=%0b inst=%h pc=%h exp 0/00000000/00000000", fetch_valid, inst_out, pc_out); end
        repeat (3) @(negedge clk);
        vectors++; if (fetch_valid !== 1'b1 || pc_out !== 32'h4) begin miscompares++; $display("FAIL lat_second valid=%0b pc=%h exp 1/00000004", fetch_valid, pc_out); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        repeat (3) @(negedge clk);
        stall = 1'b1; ack_block = 1'b1;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc_out !== 32'h4) begin miscompares++; $display("FAIL drop_pre req=%0b addr=%h pc=%h exp 1/00000008/00000004", imem_req, imem_addr, pc_out); end
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL drop_hold req=%0b addr=%h exp 1/00000008", imem_req, imem_addr); end
        vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL drop_flush valid=%0b exp 0", fetch_valid); end
        ack_block = 1'b0; stall = 1'b0;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL drop_discard req=%0b valid=%0b exp 0/0", imem_req, fetch_valid); end
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_newreq req=%0b addr=%h exp 1/00000100", imem_req, imem_addr); end
        @(negedge clk);
        vectors++; if (pc_out !== 32'h100 || inst_out !== 32'hDEAD_0100) begin miscompares++; $display("FAIL drop_newpc pc=%h inst=%h exp 00000100/dead0100", pc_out, inst_out); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        repeat (2) @(negedge clk);
        vectors++; if (fetch_valid !== 1'b1 || imem_ack !== 1'b1) begin miscompares++; $display("FAIL rack_pre valid=%0b ack=%0b exp 1/1", fetch_valid, imem_ack); end
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        vectors++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rack_flush req=%0b valid=%0b exp 0/0", imem_req, fetch_valid); end
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rack_addr got %h exp 00000100", imem_addr); end
        @(negedge clk);
        vectors++; if (pc_out !== 32'h100 || inst_out !== 32'hDEAD_0100) begin miscompares++; $display("FAIL rack_pc pc=%h inst=%h exp 00000100/dead0100", pc_out, inst_out); end
        @(negedge clk);
        vectors++; if (pc_out !== 32'h104) begin miscompares++; $display("FAIL rack_next pc=%h exp 00000104", pc_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        repeat (2) @(negedge clk);
        ack_block = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL arst_imm req=%0b valid=%0b exp 0/0", imem_req, fetch_valid); end
        vectors++; if (pc_out !== 32'h0 || inst_out !== 32'h0) begin miscompares++; $display("FAIL arst_out pc=%h inst=%h exp 0/0", pc_out, inst_out); end
        @(negedge clk);
        rst = 1'b0; ack_block = 1'b0; stall = 1'b0;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL arst_restart req=%0b addr=%h exp 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top req=%0b addr=%h exp 1/fffffffc", imem_req, imem_addr); end
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
        vectors++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4_out !== 32'h0 || inst_out !== 32'h2152_FFFC) begin miscompares++; $display("FAIL wrap_out pc=%h pc4=%h inst=%h exp fffffffc/00000000/2152fffc", pc_out, pc_plus4_out, inst_out); end
        @(negedge clk);
        vectors++; if (pc_out !== 32'h0 || inst_out !== 32'hDEAD_0000) begin miscompares++; $display("FAIL wrap_next pc=%h inst=%h exp 00000000/dead0000", pc_out, inst_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_redirect_drop();
        test_redirect_ack();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Producer end of the IF→ID pipeline wall. Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {inst, pc, pc+4} to the wall's inputs.
- Obeys the wall's hold signal (stall) and the EX-stage redirect (flush), and supplies a bubble when nothing is ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction FIFO entries; power of two, ≥2.
- BUBBLE, 32'h0000_0000, instruction emitted when the FIFO is empty; matches the wall's clear value.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  same signal as the wall's en; 1 = ID holding, do not pop.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request, held until acked.
- imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
- imem_ack  in  1  response valid this cycle; may be asserted in the same cycle imem_req rises (zero-wait memory).
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst_out  out  32  FIFO head instruction, or BUBBLE when empty.
- pc_out  out  32  PC of the head instruction; 0 when empty.
- pc_plus4_out  out  32  pc_out+4 when valid; 0 when empty.
- fetch_valid  out  1  FIFO non-empty.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE; imem_req=0.
  - All outputs go to empty values: inst_out=BUBBLE, pc_out=0, pc_plus4_out=0, fetch_valid=0.
- Output path: inst_out, pc_out, pc_plus4_out and fetch_valid are combinational from the FIFO head. No added latency toward the wall.
- Pop: at posedge when fetch_valid=1, stall=0 and redirect=0.
- Credit rule: a request may be issued only if count + outstanding < DEPTH. At most one request is outstanding.
- FSM states:
  - IDLE: imem_req=0. If the credit rule allows and redirect=0, go to WAIT next cycle with imem_addr=fetch_pc.
  - WAIT: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack with redirect=0: push {imem_rdata, fetch_pc}; fetch_pc += 4 (mod 2^32 wrap); stay in WAIT if the credit rule still holds after this cycle's push/pop, else go to IDLE.
    - On redirect without ack: go to DROP.
  - DROP: imem_req=1, imem_addr held at the stale address; the protocol does not allow withdrawing a request. On imem_ack, discard the data and go to IDLE.
- Redirect (priority over push and pop in the same cycle):
  - FIFO flushed (count=0); fetch_pc=redirect_pc & ~3.
  - An ack arriving in the redirect cycle is discarded and the FSM goes to IDLE.
  - Redirect while in DROP: fetch_pc updated; remain in DROP.
- First fetch at the new PC is requested no earlier than the cycle after the redirect.
- Simultaneous push+pop: count unchanged; the head advances.
- Full FIFO: no request issued. stall=1 indefinitely causes no request after full and no data loss.
- Empty FIFO with stall=0: the wall receives BUBBLE/0, identical to a clr bubble.
- Reset mid-WAIT: the request is dropped immediately. The memory must tolerate imem_req falling without ack.
- Throughput: 1 instr/cycle with zero-wait memory and no stall.

Decomposition:
- Shared package holds:
  - fetch FSM state encoding (IDLE, WAIT, DROP);
  - XLEN=32 and INST_BYTES=4;
  - BUBBLE/NOP constant, shared with the wall and hazard unit.
- One sub-module, fetch_fifo: DEPTH×64-bit synchronous FIFO (push, pop, flush, count, head), async reset.

Test Plan:
- Reset, zero-wait memory returning addr-based words, stall=0 → imem_addr 0,4,8,…; pc_out follows one cycle behind issue; inst_out matches memory; pc_plus4_out=pc_out+4; no gaps.
- stall=1 for 5 cycles after 2 fetches → FIFO fills at 2, imem_req drops to 0, outputs frozen at pc 0x0. After release, pcs 0x0,0x4,0x8 appear in order with no loss or duplicates.
- Memory with 3-cycle ack latency → imem_addr is stable across wait cycles and fetch_valid toggles. When stall=0 and the FIFO is empty, the wall sees BUBBLE with pc_out=0.
- redirect to 0x103 while a request to 0x8 is outstanding → FSM enters DROP and the 0x8 response is discarded. Next request is to 0x100, and the FIFO is empty on the cycle after the redirect.
- redirect in the same cycle as imem_ack and an eligible pop → data discarded, no pop, next pc_out=0x100 entry only.
- rst asserted mid-WAIT, asynchronously and off-edge → imem_req, fetch_valid and pc_out go to 0 immediately. After release, fetching restarts at RESET_PC.
- fetch_pc=0xFFFF_FFFC → next request address wraps to 0x0.
